// File: rtl/riscv_pkg.sv
// RV32I decode constants: opcodes, funct3/funct7 values and immediate formats.
package riscv_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, LOAD, JALR: return FMT_I;
            STORE:              return FMT_S;
            BRANCH:             return FMT_B;
            LUI, AUIPC:         return FMT_U;
            JAL:                return FMT_J;
            default:            return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-to-decode offer: valid/ready handshake carrying pc and instruction word.
interface id_stage_if;

    logic        in_vld;
    logic        in_rdy;
    logic [31:0] pc;
    logic [31:0] is;

    modport master (output in_vld, output pc, output is, input in_rdy);
    modport slave  (input in_vld, input pc, input is, output in_rdy);

endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator; the format is chosen from the opcode.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     is,
    output logic [XLEN-1:0] imm
);

    // Sign-extended immediate assembly for each instruction format
    always_comb begin
        case (imm_fmt(is[6:0]))
            FMT_I:   imm = {{20{is[31]}}, is[31:20]};
            FMT_S:   imm = {{20{is[31]}}, is[31:25], is[11:7]};
            FMT_B:   imm = {{19{is[31]}}, is[31], is[7], is[30:25], is[11:8], 1'b0};
            FMT_U:   imm = {is[31:12], 12'b0};
            FMT_J:   imm = {{11{is[31]}}, is[31], is[19:12], is[20], is[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, operand read/forward, load-use stall, registered output.
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int FWD  = 1
) (
    input  logic            clk,
    input  logic            rst,
    id_stage_if.slave       fe,
    input  logic            flush,
    output logic [4:0]      ra1,
    output logic [4:0]      ra2,
    output logic            re1,
    output logic            re2,
    input  logic [XLEN-1:0] rn1,
    input  logic [XLEN-1:0] rn2,
    input  logic            ex_we,
    input  logic            ex_ld,
    input  logic [4:0]      ex_wa,
    input  logic [XLEN-1:0] ex_wd,
    input  logic            mem_we,
    input  logic [4:0]      mem_wa,
    input  logic [XLEN-1:0] mem_wd,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [6:0]      t,
    output logic [2:0]      st,
    output logic            sst,
    output logic [XLEN-1:0] out1,
    output logic [XLEN-1:0] out2,
    output logic [XLEN-1:0] sd,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      wa,
    output logic            we,
    output logic [31:0]     pc_o,
    output logic            ill
);

    localparam logic [5:0] NREG_LIM = 6'(NREG);

    logic [6:0]      opc;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [4:0]      rs1, rs2, rd;
    logic            use1, use2, has_rd, known, bad_fn, bad_idx;
    logic            d_ill, d_we;
    logic [XLEN-1:0] d_imm, op1, op2, d_out1, d_out2, d_sd;
    logic            ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic            hazard, accept;

    assign opc = fe.is[6:0];
    assign rd  = fe.is[11:7];
    assign f3  = fe.is[14:12];
    assign rs1 = fe.is[19:15];
    assign rs2 = fe.is[24:20];
    assign f7  = fe.is[31:25];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .is  (fe.is),
        .imm (d_imm)
    );

    // Operand usage, legality and register-write decode
    always_comb begin
        use1   = 1'b0;
        use2   = 1'b0;
        has_rd = 1'b0;
        known  = 1'b1;
        bad_fn = 1'b0;
        case (opc)
            OP: begin
                use1   = 1'b1;
                use2   = 1'b1;
                has_rd = 1'b1;
                bad_fn = !((f7 == F7_BASE) ||
                           (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)));
            end
            OP_IMM: begin
                use1   = 1'b1;
                has_rd = 1'b1;
                if (f3 == F3_SLL)
                    bad_fn = (f7 != F7_BASE);
                else if (f3 == F3_SRL_SRA)
                    bad_fn = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
            LOAD, JALR: begin
                use1   = 1'b1;
                has_rd = 1'b1;
            end
            STORE, BRANCH: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            LUI, AUIPC, JAL: has_rd = 1'b1;
            default: known = 1'b0;
        endcase
        bad_idx = (use1   && {1'b0, rs1} >= NREG_LIM) ||
                  (use2   && {1'b0, rs2} >= NREG_LIM) ||
                  (has_rd && {1'b0, rd}  >= NREG_LIM);
        d_ill = !known || bad_fn || bad_idx;
        d_we  = has_rd && (rd != 5'd0) && !d_ill;
    end

    assign ex_hit1  = ex_we  && (ex_wa  != 5'd0) && (ex_wa  == rs1);
    assign ex_hit2  = ex_we  && (ex_wa  != 5'd0) && (ex_wa  == rs2);
    assign mem_hit1 = mem_we && (mem_wa != 5'd0) && (mem_wa == rs1);
    assign mem_hit2 = mem_we && (mem_wa != 5'd0) && (mem_wa == rs2);

    // Source values: EX beats MEM beats register file; x0 always reads zero
    always_comb begin
        op1 = rn1;
        op2 = rn2;
        if (FWD != 0) begin
            if (ex_hit1)       op1 = ex_wd;
            else if (mem_hit1) op1 = mem_wd;
            if (ex_hit2)       op2 = ex_wd;
            else if (mem_hit2) op2 = mem_wd;
        end
        if (rs1 == 5'd0) op1 = '0;
        if (rs2 == 5'd0) op2 = '0;
    end

    // Stall on load-use, or on any RAW against EX/MEM when forwarding is absent
    always_comb begin
        hazard = ex_ld && ((use1 && ex_hit1) || (use2 && ex_hit2));
        if (FWD == 0)
            hazard = hazard || (use1 && (ex_hit1 || mem_hit1)) ||
                               (use2 && (ex_hit2 || mem_hit2));
    end

    // ALU operand and store-data selection
    always_comb begin
        case (opc)
            LUI:        d_out1 = '0;
            AUIPC, JAL: d_out1 = fe.pc;
            default:    d_out1 = op1;
        endcase
        case (opc)
            OP, BRANCH: d_out2 = op2;
            JAL, JALR:  d_out2 = XLEN'(4);
            default:    d_out2 = d_imm;
        endcase
        d_sd = (opc == STORE || opc == BRANCH) ? op2 : '0;
    end

    assign ra1       = rst ? 5'd0 : rs1;
    assign ra2       = rst ? 5'd0 : rs2;
    assign re1       = !rst && use1;
    assign re2       = !rst && use2;
    assign fe.in_rdy = !rst && (!out_vld || out_rdy) && !hazard && !flush;
    assign accept    = fe.in_vld && fe.in_rdy;

    // Output pipeline register: flush kills, accept loads, consume drains
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            t       <= '0;
            st      <= '0;
            sst     <= 1'b0;
            out1    <= '0;
            out2    <= '0;
            sd      <= '0;
            imm     <= '0;
            wa      <= '0;
            we      <= 1'b0;
            pc_o    <= '0;
            ill     <= 1'b0;
        end else if (flush) begin
            out_vld <= 1'b0;
        end else if (accept) begin
            out_vld <= (fe.is != 32'd0);
            t       <= opc;
            st      <= f3;
            sst     <= fe.is[30];
            out1    <= d_out1;
            out2    <= d_out2;
            sd      <= d_sd;
            imm     <= d_imm;
            wa      <= rd;
            we      <= d_we;
            pc_o    <= fe.pc;
            ill     <= d_ill;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage (NREG=32 main instance, NREG=16 side instance).
module tb_id_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, out_rdy;
    logic [4:0]  ra1, ra2;
    logic        re1, re2;
    logic [31:0] rn1, rn2;
    logic        ex_we, ex_ld, mem_we;
    logic [4:0]  ex_wa, mem_wa;
    logic [31:0] ex_wd, mem_wd;
    logic        out_vld, sst, we, ill;
    logic [6:0]  t;
    logic [2:0]  st;
    logic [31:0] out1, out2, sd, imm, pc_o;
    logic [4:0]  wa;

    logic [4:0]  b_ra1, b_ra2, b_wa;
    logic        b_re1, b_re2, b_out_vld, b_sst, b_we, b_ill;
    logic [6:0]  b_t;
    logic [2:0]  b_st;
    logic [31:0] b_out1, b_out2, b_sd, b_imm, b_pc_o;

    int checks = 0;
    int errors = 0;

    id_stage_if fe ();
    id_stage_if fe16 ();

    assign fe16.in_vld = fe.in_vld;
    assign fe16.pc     = fe.pc;
    assign fe16.is     = fe.is;

    id_stage #(.XLEN(32), .NREG(32), .FWD(1)) dut (
        .clk(clk), .rst(rst), .fe(fe), .flush(flush),
        .ra1(ra1), .ra2(ra2), .re1(re1), .re2(re2), .rn1(rn1), .rn2(rn2),
        .ex_we(ex_we), .ex_ld(ex_ld), .ex_wa(ex_wa), .ex_wd(ex_wd),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .out_vld(out_vld), .out_rdy(out_rdy), .t(t), .st(st), .sst(sst),
        .out1(out1), .out2(out2), .sd(sd), .imm(imm), .wa(wa), .we(we),
        .pc_o(pc_o), .ill(ill)
    );

    id_stage #(.XLEN(32), .NREG(16), .FWD(1)) dut16 (
        .clk(clk), .rst(rst), .fe(fe16), .flush(flush),
        .ra1(b_ra1), .ra2(b_ra2), .re1(b_re1), .re2(b_re2), .rn1(rn1), .rn2(rn2),
        .ex_we(ex_we), .ex_ld(ex_ld), .ex_wa(ex_wa), .ex_wd(ex_wd),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .out_vld(b_out_vld), .out_rdy(out_rdy), .t(b_t), .st(b_st), .sst(b_sst),
        .out1(b_out1), .out2(b_out2), .sd(b_sd), .imm(b_imm), .wa(b_wa), .we(b_we),
        .pc_o(b_pc_o), .ill(b_ill)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fe.in_vld = 1'b0; fe.is = '0; fe.pc = '0;
        flush = 1'b0; out_rdy = 1'b1;
        ex_we = 1'b0; ex_ld = 1'b0; ex_wa = '0; ex_wd = '0;
        mem_we = 1'b0; mem_wa = '0; mem_wd = '0;
        rn1 = '0; rn2 = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; fe.in_vld = 1'b1; fe.is = 32'h002082B3; fe.pc = 32'h44;
        cycle(); cycle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_out_vld: got %h expected 0", out_vld); end
        checks++; if (ill !== 1'b0) begin errors++; $display("FAIL rst_ill: got %h expected 0", ill); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we: got %h expected 0", we); end
        checks++; if (t !== 7'h00) begin errors++; $display("FAIL rst_t: got %h expected 00", t); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc_o: got %h expected 0", pc_o); end
        checks++; if (ra1 !== 5'd0) begin errors++; $display("FAIL rst_ra1: got %0d expected 0", ra1); end
        checks++; if (re1 !== 1'b0) begin errors++; $display("FAIL rst_re1: got %h expected 0", re1); end
        rst = 1'b0; fe.in_vld = 1'b0;
        #1;
        checks++; if (ra2 !== 5'd2) begin errors++; $display("FAIL post_rst_ra2: got %0d expected 2", ra2); end
        checks++; if (re2 !== 1'b1) begin errors++; $display("FAIL post_rst_re2: got %h expected 1", re2); end
        cycle();
    endtask

    task automatic test_ori();
        idle();
        fe.in_vld = 1'b1; fe.is = 32'h0F00E193; fe.pc = 32'h40; rn1 = 32'hF; rn2 = 32'hDEAD;
        #1;
        checks++; if (fe.in_rdy !== 1'b1) begin errors++; $display("FAIL ori_in_rdy: got %h expected 1", fe.in_rdy); end
        checks++; if (ra1 !== 5'd1) begin errors++; $display("FAIL ori_ra1: got %0d expected 1", ra1); end
        checks++; if (re2 !== 1'b0) begin errors++; $display("FAIL ori_re2: got %h expected 0", re2); end
        cycle();
        fe.in_vld = 1'b0;
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL ori_out_vld: got %h expected 1", out_vld); end
        checks++; if (out1 !== 32'hF) begin errors++; $display("FAIL ori_out1: got %h expected 0000000f", out1); end
        checks++; if (out2 !== 32'hF0) begin errors++; $display("FAIL ori_out2: got %h expected 000000f0", out2); end
        checks++; if (wa !== 5'd3) begin errors++; $display("FAIL ori_wa: got %0d expected 3", wa); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL ori_we: got %h expected 1", we); end
        checks++; if (st !== 3'd6) begin errors++; $display("FAIL ori_st: got %0d expected 6", st); end
        checks++; if (t !== 7'h13) begin errors++; $display("FAIL ori_t: got %h expected 13", t); end
        checks++; if (pc_o !== 32'h40) begin errors++; $display("FAIL ori_pc_o: got %h expected 00000040", pc_o); end
        checks++; if (sd !== 32'h0) begin errors++; $display("FAIL ori_sd: got %h expected 0", sd); end
        cycle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL ori_drain: got %h expected 0", out_vld); end
    endtask

    task automatic test_back_to_back();
        idle();
        rn1 = 32'h11; rn2 = 32'h22;
        ex_we = 1'b1; ex_wa = 5'd2; ex_wd = 32'h55;
        mem_we = 1'b1; mem_wa = 5'd2; mem_wd = 32'h77;
        fe.in_vld = 1'b1; fe.is = 32'h002082B3; fe.pc = 32'h80;
        cycle();
        checks++; if (out2 !== 32'h55) begin errors++; $display("FAIL fwd_ex_wins: got %h expected 00000055", out2); end
        checks++; if (out1 !== 32'h11) begin errors++; $display("FAIL fwd_rn1: got %h expected 00000011", out1); end
        checks++; if (wa !== 5'd5) begin errors++; $display("FAIL fwd_wa: got %0d expected 5", wa); end
        mem_wa = 5'd1; fe.pc = 32'h84;
        #1;
        checks++; if (fe.in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_in_rdy: got %h expected 1", fe.in_rdy); end
        cycle();
        checks++; if (out1 !== 32'h77) begin errors++; $display("FAIL fwd_mem1: got %h expected 00000077", out1); end
        checks++; if (out2 !== 32'h55) begin errors++; $display("FAIL fwd_ex2: got %h expected 00000055", out2); end
        checks++; if (pc_o !== 32'h84) begin errors++; $display("FAIL b2b_pc_o: got %h expected 00000084", pc_o); end
        ex_wa = 5'd0; mem_we = 1'b0; fe.is = 32'h002002B3; fe.pc = 32'h88;
        cycle();
        fe.in_vld = 1'b0;
        checks++; if (out1 !== 32'h0) begin errors++; $display("FAIL x0_out1: got %h expected 0", out1); end
        checks++; if (out2 !== 32'h22) begin errors++; $display("FAIL x0_ex_wa0: got %h expected 00000022", out2); end
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL b2b_out_vld: got %h expected 1", out_vld); end
        cycle();
    endtask

    task automatic test_load_use();
        idle();
        ex_we = 1'b1; ex_ld = 1'b1; ex_wa = 5'd4; ex_wd = 32'hBAD;
        fe.in_vld = 1'b1; fe.is = 32'h00120313; fe.pc = 32'hC0; rn1 = 32'h1234;
        #1;
        checks++; if (fe.in_rdy !== 1'b0) begin errors++; $display("FAIL lu_stall: got %h expected 0", fe.in_rdy); end
        cycle();
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %h expected 0", out_vld); end
        ex_we = 1'b0; ex_ld = 1'b0; mem_we = 1'b1; mem_wa = 5'd4; mem_wd = 32'h99;
        #1;
        checks++; if (fe.in_rdy !== 1'b1) begin errors++; $display("FAIL lu_release: got %h expected 1", fe.in_rdy); end
        cycle();
        fe.in_vld = 1'b0;
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL lu_accept: got %h expected 1", out_vld); end
        checks++; if (out1 !== 32'h99) begin errors++; $display("FAIL lu_out1: got %h expected 00000099", out1); end
        checks++; if (out2 !== 32'h1) begin errors++; $display("FAIL lu_out2: got %h expected 00000001", out2); end
        checks++; if (wa !== 5'd6) begin errors++; $display("FAIL lu_wa: got %0d expected 6", wa); end
        cycle();
    endtask

    task automatic test_stall_flush();
        idle();
        rn1 = 32'hA; rn2 = 32'hB; out_rdy = 1'b0;
        fe.in_vld = 1'b1; fe.is = 32'h00208463; fe.pc = 32'h200;
        cycle();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL beq_vld: got %h expected 1", out_vld); end
        checks++; if (imm !== 32'h8) begin errors++; $display("FAIL beq_imm: got %h expected 00000008", imm); end
        checks++; if (out2 !== 32'hB) begin errors++; $display("FAIL beq_out2: got %h expected 0000000b", out2); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL beq_we: got %h expected 0", we); end
        fe.is = 32'h0F00E193; fe.pc = 32'h204; rn1 = 32'h1; rn2 = 32'h2;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (fe.in_rdy !== 1'b0) begin errors++; $display("FAIL stall_in_rdy[%0d]: got %h expected 0", i, fe.in_rdy); end
            cycle();
            checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL stall_vld[%0d]: got %h expected 1", i, out_vld); end
            checks++; if (out1 !== 32'hA) begin errors++; $display("FAIL stall_out1[%0d]: got %h expected 0000000a", i, out1); end
            checks++; if (sd !== 32'hB) begin errors++; $display("FAIL stall_sd[%0d]: got %h expected 0000000b", i, sd); end
            checks++; if (pc_o !== 32'h200) begin errors++; $display("FAIL stall_pc_o[%0d]: got %h expected 00000200", i, pc_o); end
        end
        flush = 1'b1; out_rdy = 1'b1;
        #1;
        checks++; if (fe.in_rdy !== 1'b0) begin errors++; $display("FAIL flush_in_rdy: got %h expected 0", fe.in_rdy); end
        cycle();
        flush = 1'b0; fe.in_vld = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL flush_vld: got %h expected 0", out_vld); end
        checks++; if (pc_o !== 32'h200) begin errors++; $display("FAIL flush_no_accept: got %h expected 00000200", pc_o); end
        cycle();
    endtask

    task automatic test_formats();
        idle();
        rn1 = 32'h10; rn2 = 32'h20;
        fe.in_vld = 1'b1; fe.is = 32'hABCDE3B7; fe.pc = 32'h300;
        cycle();
        checks++; if (out1 !== 32'h0) begin errors++; $display("FAIL lui_out1: got %h expected 0", out1); end
        checks++; if (out2 !== 32'hABCDE000) begin errors++; $display("FAIL lui_out2: got %h expected abcde000", out2); end
        checks++; if (imm !== 32'hABCDE000) begin errors++; $display("FAIL lui_imm: got %h expected abcde000", imm); end
        checks++; if (wa !== 5'd7) begin errors++; $display("FAIL lui_wa: got %0d expected 7", wa); end
        fe.is = 32'hFF9FF0EF; fe.pc = 32'h100;
        cycle();
        checks++; if (out1 !== 32'h100) begin errors++; $display("FAIL jal_out1: got %h expected 00000100", out1); end
        checks++; if (imm !== 32'hFFFFFFF8) begin errors++; $display("FAIL jal_imm: got %h expected fffffff8", imm); end
        checks++; if (out2 !== 32'h4) begin errors++; $display("FAIL jal_out2: got %h expected 00000004", out2); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL jal_we: got %h expected 1", we); end
        fe.is = 32'h4030D293; fe.pc = 32'h104;
        cycle();
        checks++; if (imm !== 32'h403) begin errors++; $display("FAIL srai_imm: got %h expected 00000403", imm); end
        checks++; if (sst !== 1'b1) begin errors++; $display("FAIL srai_sst: got %h expected 1", sst); end
        checks++; if (ill !== 1'b0) begin errors++; $display("FAIL srai_ill: got %h expected 0", ill); end
        checks++; if (out1 !== 32'h10) begin errors++; $display("FAIL srai_out1: got %h expected 00000010", out1); end
        fe.is = 32'h0020A623; fe.pc = 32'h108;
        cycle();
        fe.in_vld = 1'b0;
        checks++; if (out2 !== 32'hC) begin errors++; $display("FAIL sw_out2: got %h expected 0000000c", out2); end
        checks++; if (sd !== 32'h20) begin errors++; $display("FAIL sw_sd: got %h expected 00000020", sd); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL sw_we: got %h expected 0", we); end
        cycle();
    endtask

    task automatic test_illegal();
        idle();
        fe.in_vld = 1'b1; fe.is = 32'h000001FF; fe.pc = 32'h400;
        cycle();
        checks++; if (ill !== 1'b1) begin errors++; $display("FAIL op7f_ill: got %h expected 1", ill); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL op7f_we: got %h expected 0", we); end
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL op7f_vld: got %h expected 1", out_vld); end
        fe.is = 32'h022082B3;
        cycle();
        checks++; if (ill !== 1'b1) begin errors++; $display("FAIL f7_op_ill: got %h expected 1", ill); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL f7_op_we: got %h expected 0", we); end
        fe.is = 32'h40309293;
        cycle();
        checks++; if (ill !== 1'b1) begin errors++; $display("FAIL slli_f7_ill: got %h expected 1", ill); end
        fe.is = 32'h000008B3;
        cycle();
        checks++; if (ill !== 1'b0) begin errors++; $display("FAIL x17_nreg32_ill: got %h expected 0", ill); end
        checks++; if (wa !== 5'd17) begin errors++; $display("FAIL x17_nreg32_wa: got %0d expected 17", wa); end
        checks++; if (b_ill !== 1'b1) begin errors++; $display("FAIL x17_nreg16_ill: got %h expected 1", b_ill); end
        checks++; if (b_we !== 1'b0) begin errors++; $display("FAIL x17_nreg16_we: got %h expected 0", b_we); end
        checks++; if (b_out_vld !== 1'b1) begin errors++; $display("FAIL x17_nreg16_vld: got %h expected 1", b_out_vld); end
        fe.is = 32'h0;
        cycle();
        fe.in_vld = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL bubble_vld: got %h expected 0", out_vld); end
        cycle();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        out_rdy = 1'b0; rn1 = 32'hF;
        fe.in_vld = 1'b1; fe.is = 32'h0F00E193; fe.pc = 32'h500;
        cycle();
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL rms_held: got %h expected 1", out_vld); end
        rst = 1'b1;
        cycle();
        rst = 1'b0; fe.in_vld = 1'b0;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rms_vld: got %h expected 0", out_vld); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rms_pc_o: got %h expected 0", pc_o); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rms_we: got %h expected 0", we); end
        cycle();
    endtask

    initial begin
        test_reset();
        test_ori();
        test_back_to_back();
        test_load_use();
        test_stall_flush();
        test_formats();
        test_illegal();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
